// File: rtl/ro_meas_pkg.sv
// Shared types and helpers for the ring-oscillator frequency meter.
package ro_meas_pkg;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Multi-flop synchroniser for one asynchronous ring-derived signal, followed
// by a rising-edge detector producing a single-cycle pulse per synced edge.
module ro_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the async input through the synchroniser chain and remember the last synced level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Frequency meter for a ring-oscillator bank: counts synced rising edges of
// one selected channel over a window of gate_len clk cycles, single-shot or
// continuous. All channels are edge-detected all the time so a channel
// change needs no settling.
module ro_freq_counter
  import ro_meas_pkg::*;
#(
  parameter int  CHANNELS    = 4,
  parameter int  CNT_W       = 16,
  parameter int  GATE_W      = 12,
  parameter int  SYNC_STAGES = 2,
  localparam int CH_W        = ch_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] ro_in,
  input  logic [CH_W-1:0]     ch_sel,
  input  logic [GATE_W-1:0]   gate_len,
  input  logic                mode,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    count,
  output logic                overflow,
  output logic [CH_W-1:0]     ch_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CHANNELS-1:0] rise_s;
  logic                rise_sel_s;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [GATE_W-1:0]   len_q, len_d;
  logic [GATE_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [CH_W-1:0]     chout_q, chout_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [CNT_W-1:0]    cnt_inc_s;
  logic                sat_inc_s;
  logic                res_load_s;
  logic [CNT_W-1:0]    res_cnt_s;
  logic                res_sat_s;
  logic [CH_W-1:0]     res_ch_s;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    ro_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (ro_in[g]),
      .rise_o  (rise_s[g])
    );
  end

  assign rise_sel_s = rise_s[ch_q];

  // Saturating increment of the edge counter; the sticky flag records a lost edge at full scale.
  always_comb begin
    cnt_inc_s = cnt_q;
    sat_inc_s = sat_q;
    if (rise_sel_s) begin
      if (cnt_q == CNT_MAX) begin
        sat_inc_s = 1'b1;
      end else begin
        cnt_inc_s = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_inc_s = cnt_q;
    end
  end

  // Sequencer next-state, counter control and result capture.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    len_d      = len_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    res_load_s = 1'b0;
    res_cnt_s  = '0;
    res_sat_s  = 1'b0;
    res_ch_s   = ch_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          ch_d  = ch_sel;
          len_d = gate_len;
          win_d = gate_len;
          cnt_d = '0;
          sat_d = 1'b0;
          if (gate_len == GATE_W'(0)) begin
            // Empty window: report a zero result straight away.
            state_d    = ST_DONE;
            res_load_s = 1'b1;
            res_ch_s   = ch_sel;
          end else begin
            state_d = ST_GATE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GATE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc_s;
          sat_d = sat_inc_s;
          if (win_q == GATE_W'(1)) begin
            // Last gate cycle: its edge is included in the published result.
            state_d    = ST_DONE;
            res_load_s = 1'b1;
            res_cnt_s  = cnt_inc_s;
            res_sat_s  = sat_inc_s;
          end else begin
            win_d = win_q - GATE_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (mode) begin
          // Continuous: restart with the captured channel and window; edges in this cycle are dropped.
          win_d = len_q;
          cnt_d = '0;
          sat_d = 1'b0;
          if (len_q == GATE_W'(0)) begin
            state_d    = ST_DONE;
            res_load_s = 1'b1;
          end else begin
            state_d = ST_GATE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = res_load_s;
    if (res_load_s) begin
      count_d = res_cnt_s;
      ovf_d   = res_sat_s;
      chout_d = res_ch_s;
    end else begin
      count_d = count_q;
      ovf_d   = ovf_q;
      chout_d = chout_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      len_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      chout_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      len_q   <= len_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      chout_q <= chout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign ch_out   = chout_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Self-checking bench for ro_freq_counter. Two instances share all inputs:
// a 16-bit counter and a 4-bit one used to exercise saturation. Expected
// counts come from a log of every rising edge the bench drives on ro_in.
module tb_ro_freq_counter;

  localparam int CH = 4;
  localparam int GW = 12;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] ro_in;
  logic [1:0]    ch_sel;
  logic [GW-1:0] gate_len;
  logic          mode, start, abort;

  logic          busy, done, overflow;
  logic [15:0]   count;
  logic [1:0]    ch_out;
  logic          busy4, done4, ovf4;
  logic [3:0]    count4;
  logic [1:0]    ch4;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int half [CH];
  int ph [CH];
  int rises [CH][$];
  int s, e, last, seen;

  ro_freq_counter #(.CHANNELS(CH), .CNT_W(16), .GATE_W(GW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .ro_in(ro_in), .ch_sel(ch_sel), .gate_len(gate_len),
    .mode(mode), .start(start), .abort(abort), .busy(busy), .done(done),
    .count(count), .overflow(overflow), .ch_out(ch_out)
  );

  ro_freq_counter #(.CHANNELS(CH), .CNT_W(4), .GATE_W(GW), .SYNC_STAGES(SS)) dut4 (
    .clk(clk), .reset(reset), .ro_in(ro_in), .ch_sel(ch_sel), .gate_len(gate_len),
    .mode(mode), .start(start), .abort(abort), .busy(busy4), .done(done4),
    .count(count4), .overflow(ovf4), .ch_out(ch4)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Ring stimulus: each channel toggles every half[i] cycles; rising edges are logged by cycle.
  initial begin
    ro_in = '0;
    for (int i = 0; i < CH; i++) begin
      half[i] = 3;
      ph[i]   = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) begin
        ph[i] = ph[i] + 1;
        if (ph[i] >= half[i]) begin
          ph[i] = 0;
          ro_in[i] = ~ro_in[i];
          if (ro_in[i]) rises[i].push_back(cyc);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A rise driven during cycle c is visible to the counter in cycle c+SS; count those inside [a,b].
  function automatic int edges_in(input int ch, input int a, input int b);
    int n = 0;
    foreach (rises[ch][i]) begin
      if (rises[ch][i] + SS >= a && rises[ch][i] + SS <= b) n++;
    end
    return n;
  endfunction

  function automatic int sat_to(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // One single-shot measurement; optionally pokes start with other settings while gating.
  task automatic run_single(input int ch, input int len, input bit poke, input string tag);
    int st, ev;
    @(negedge clk);
    ch_sel = 2'(ch); gate_len = GW'(len); mode = 1'b0; start = 1'b1;
    st = cyc;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    if (poke && len > 8) begin
      repeat (3) @(negedge clk);
      ch_sel = 2'((ch + 2) % CH); gate_len = GW'(5); start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    while (!done && cyc < st + len + 40) @(negedge clk);
    check({tag, "_done_cyc"}, cyc, st + len + 1);
    ev = edges_in(ch, st + 1, st + len);
    check({tag, "_count"}, {16'd0, count}, sat_to(ev, 65535));
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ev > 65535});
    check({tag, "_count4"}, {28'd0, count4}, sat_to(ev, 15));
    check({tag, "_ovf4"}, {31'd0, ovf4}, {31'd0, ev > 15});
    check({tag, "_ch_out"}, {30'd0, ch_out}, ch);
    check({tag, "_ch4"}, {30'd0, ch4}, ch);
    check({tag, "_done4"}, {31'd0, done4}, 32'd1);
    @(negedge clk);
    check({tag, "_busy_after"}, {30'd0, busy, busy4}, 32'd0);
    check({tag, "_done_after"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; ch_sel = '0; gate_len = '0; mode = 1'b0; start = 1'b0; abort = 1'b0;
    half[0] = 2; half[1] = 3;

    // Reset held for three cycles with the rings running.
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_count", {16'd0, count}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_ch_out", {30'd0, ch_out}, 32'd0);
    reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("idle_after_rst", seen, 0);

    // Basic window on channel 1, period 8, window 64.
    half[1] = 4;
    run_single(1, 64, 1'b0, "p8_w64");

    // Empty window.
    run_single(3, 0, 1'b0, "len0");

    // Saturation of the narrow counter, then a slow ring that fits.
    half[0] = 2;
    run_single(0, 100, 1'b0, "sat");
    half[0] = 20;
    run_single(0, 100, 1'b0, "nosat");

    // Abort wins over start in IDLE.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_idle_busy", {31'd0, busy}, 32'd0);

    // Continuous mode, period 10, window 20, aborted mid third window.
    half[2] = 5;
    @(negedge clk);
    ch_sel = 2'd2; gate_len = GW'(20); mode = 1'b1; start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    last = 0;
    for (int k = 1; k <= 2; k++) begin
      while (!done && cyc < s + 21 * k + 5) @(negedge clk);
      check("cont_done_cyc", cyc, s + 21 * k);
      e = edges_in(2, s + 21 * (k - 1) + 1, s + 21 * (k - 1) + 20);
      check("cont_count", {16'd0, count}, e);
      check("cont_count_is2", {16'd0, count}, 32'd2);
      last = e;
      @(negedge clk);
    end
    while (cyc < s + 50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; mode = 1'b0;
    check("cont_abort_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("cont_no_done", seen, 0);
    check("cont_count_held", {16'd0, count}, last);

    // Start pulses with other settings while gating are ignored.
    half[1] = 3;
    run_single(1, 30, 1'b1, "poke");

    // Randomised single-shot runs.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < CH; i++) half[i] = $urandom_range(2, 12);
      run_single($urandom_range(0, CH - 1), $urandom_range(1, 250), r[0], "rnd");
    end

    // Reset in the middle of a gate window clears everything.
    half[1] = 3;
    run_single(1, 30, 1'b0, "pre_rst");
    @(negedge clk);
    ch_sel = 2'd2; gate_len = GW'(200); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_count", {16'd0, count}, 32'd0);
    check("midrst_count4", {28'd0, count4}, 32'd0);
    check("midrst_ovf", {30'd0, overflow, ovf4}, 32'd0);
    check("midrst_ch_out", {30'd0, ch_out}, 32'd0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("midrst_quiet", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
